// File: rtl/rom_bus_arbiter_pkg.sv
// rom_bus_arbiter_pkg: shared state encoding, cycle-count defaults and data width for the SRAM0 arbiter
package rom_bus_arbiter_pkg;
  localparam int DQ_W = 8;
  localparam int CNT_W = 8;
  localparam int DEF_SNES_RD_CYC = 6;
  localparam int DEF_SNES_WR_CYC = 6;
  localparam int DEF_MCU_RD_CYC = 5;
  localparam int DEF_MCU_WR_CYC = 5;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SNES_RD = 3'd1,
    SNES_WR = 3'd2,
    MCU_RD  = 3'd3,
    MCU_WR  = 3'd4
  } state_t;
  function automatic logic is_snes(state_t s);
    return s == SNES_RD || s == SNES_WR;
  endfunction
  function automatic logic is_mcu(state_t s);
    return s == MCU_RD || s == MCU_WR;
  endfunction
  function automatic logic is_rd(state_t s);
    return s == SNES_RD || s == MCU_RD;
  endfunction
  function automatic logic is_wr(state_t s);
    return s == SNES_WR || s == MCU_WR;
  endfunction
endpackage

// File: rtl/rom_bus_arbiter_if.sv
// rom_bus_arbiter_if: MCU request/response handshake to the SRAM0 arbiter
// Ports (signals):
//   req      MCU request level, held until rdy
//   we       1=write, 0=read; sampled at accept
//   addr     MCU address; sampled at accept
//   wr_data  MCU write data; sampled at accept
//   rd_data  read result, valid at rdy, held
//   rdy      1-cycle completion pulse
interface rom_bus_arbiter_if import rom_bus_arbiter_pkg::*; #(
  parameter int ADDR_W = 24
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DQ_W-1:0]   wr_data;
  logic [DQ_W-1:0]   rd_data;
  logic              rdy;
  modport master (output req, we, addr, wr_data, input rd_data, rdy);
  modport slave (input req, we, addr, wr_data, output rd_data, rdy);
endinterface

// File: rtl/rom_bus_arbiter_sram_cycle_timer.sv
// rom_bus_arbiter_sram_cycle_timer: down-counter timing one SRAM access window
// Ports:
//   clk, rst_n  clock, async active-low reset
//   load        load load_val this cycle (access entry)
//   load_val    N-1 for the access being entered
//   cnt_nxt     value the counter takes at the next edge
//   last        counter is 0 (last cycle of the window, or idle)
module rom_bus_arbiter_sram_cycle_timer import rom_bus_arbiter_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             last
);
  logic [CNT_W-1:0] cnt;
  assign last = cnt == '0;
  // Holds at 0 when idle so last stays asserted and arbitration runs every idle cycle.
  assign cnt_nxt = load ? load_val : last ? '0 : cnt - 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= cnt_nxt;
endmodule

// File: rtl/rom_bus_arbiter.sv
// rom_bus_arbiter: sequences SRAM0 CE/OE/WE cycles, SNES strict priority, MCU slotted into gaps
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   snes_rd_start/wr_start      1-cycle SNES cycle-start strobes
//   rom_addr/rom_hit/is_writable translated SNES address and decode flags
//   snes_wr_data/snes_rd_data   SNES write data in, last SNES read result (held)
//   mcu                         MCU handshake (slave side)
//   sram_*                      registered SRAM0 pins; sram_dq_in is the pad read data
//   snes_overrun                sticky: SNES start while a SNES access was pending/active
module rom_bus_arbiter import rom_bus_arbiter_pkg::*; #(
  parameter int ADDR_W      = 24,
  parameter int SNES_RD_CYC = DEF_SNES_RD_CYC,
  parameter int SNES_WR_CYC = DEF_SNES_WR_CYC,
  parameter int MCU_RD_CYC  = DEF_MCU_RD_CYC,
  parameter int MCU_WR_CYC  = DEF_MCU_WR_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              snes_rd_start,
  input  logic              snes_wr_start,
  input  logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_hit,
  input  logic              is_writable,
  input  logic [DQ_W-1:0]   snes_wr_data,
  output logic [DQ_W-1:0]   snes_rd_data,
  rom_bus_arbiter_if.slave  mcu,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [DQ_W-1:0]   sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DQ_W-1:0]   sram_dq_in,
  output logic              snes_overrun
);
  state_t            state, nxt;
  logic              hit_rd, hit_wr, s_start, s_req, s_pend, s_we, e_we;
  logic [ADDR_W-1:0] s_addr, e_addr;
  logic [DQ_W-1:0]   s_data, e_data, mcu_rd_q;
  logic              go, enter, mcu_ok, last, rdy_q;
  logic [CNT_W-1:0]  load_val, cnt_nxt;
  assign hit_rd = snes_rd_start & rom_hit;
  assign hit_wr = snes_wr_start & rom_hit & is_writable;
  assign s_start = hit_rd | hit_wr;
  // A start arriving in the arbitration cycle is used directly so SNES beats a same-cycle MCU request.
  assign s_req = s_pend | s_start;
  assign e_we = s_start ? ~hit_rd : s_we;
  assign e_addr = s_start ? rom_addr : s_addr;
  assign e_data = s_start ? snes_wr_data : s_data;
  assign go = state == IDLE || last;
  // The request level seen during an MCU access (and its rdy cycle) belongs to that access.
  assign mcu_ok = mcu.req & ~rdy_q & ~is_mcu(state);
  always_comb begin
    nxt = state;
    if (go) nxt = s_req ? (e_we ? SNES_WR : SNES_RD) : mcu_ok ? (mcu.we ? MCU_WR : MCU_RD) : IDLE;
  end
  assign enter = go & (nxt != IDLE);
  assign load_val = nxt == SNES_RD ? CNT_W'(SNES_RD_CYC - 1) :
                    nxt == SNES_WR ? CNT_W'(SNES_WR_CYC - 1) :
                    nxt == MCU_RD  ? CNT_W'(MCU_RD_CYC - 1)  :
                    nxt == MCU_WR  ? CNT_W'(MCU_WR_CYC - 1)  : '0;
  rom_bus_arbiter_sram_cycle_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (enter),
    .load_val(load_val),
    .cnt_nxt (cnt_nxt),
    .last    (last)
  );
  assign mcu.rdy = rdy_q;
  assign mcu.rd_data = mcu_rd_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      s_pend <= 1'b0;
      s_we <= 1'b0;
      s_addr <= '0;
      s_data <= '0;
      snes_overrun <= 1'b0;
      snes_rd_data <= '0;
      mcu_rd_q <= '0;
      rdy_q <= 1'b0;
      sram_addr <= '0;
      sram_dq_out <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_dq_oe <= 1'b0;
    end else begin
      state <= nxt;
      // Arbitration always serves a pending SNES request, so go alone clears it.
      s_pend <= s_req & ~go;
      if (s_start) begin
        s_we <= ~hit_rd;
        s_addr <= rom_addr;
        s_data <= snes_wr_data;
      end
      if (s_start && (s_pend || is_snes(state))) snes_overrun <= 1'b1;
      if (last && state == SNES_RD) snes_rd_data <= sram_dq_in;
      if (last && state == MCU_RD) mcu_rd_q <= sram_dq_in;
      rdy_q <= is_mcu(state) & last;
      if (enter) begin
        sram_addr <= is_snes(nxt) ? e_addr : mcu.addr;
        sram_dq_out <= is_snes(nxt) ? e_data : mcu.wr_data;
      end
      sram_ce_n <= nxt == IDLE;
      sram_oe_n <= ~is_rd(nxt);
      sram_dq_oe <= is_wr(nxt);
      // First and last write cycles keep WE high for address/data setup and hold.
      sram_we_n <= ~(is_wr(nxt) && cnt_nxt != load_val && cnt_nxt != '0);
    end
endmodule

// File: tb/tb_rom_bus_arbiter.sv
// tb_rom_bus_arbiter: directed self-checking bench for rom_bus_arbiter
module tb_rom_bus_arbiter;
  import rom_bus_arbiter_pkg::*;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        snes_rd_start = 0, snes_wr_start = 0, rom_hit = 0, is_writable = 0;
  logic [23:0] rom_addr = '0, sram_addr;
  logic [7:0]  snes_wr_data = '0, snes_rd_data, sram_dq_out, sram_dq_in = '0;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, snes_overrun;
  int total = 0, bad = 0;
  int n_ce, n_oe, n_we, n_dqoe, n_rdy, f_ce, l_ce, f_we, f_rdy;
  logic [23:0] f_addr, l_addr;
  logic [7:0]  f_dq;
  rom_bus_arbiter_if #(.ADDR_W(24)) mcu_bus ();
  rom_bus_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .snes_rd_start(snes_rd_start),
    .snes_wr_start(snes_wr_start),
    .rom_addr     (rom_addr),
    .rom_hit      (rom_hit),
    .is_writable  (is_writable),
    .snes_wr_data (snes_wr_data),
    .snes_rd_data (snes_rd_data),
    .mcu          (mcu_bus),
    .sram_addr    (sram_addr),
    .sram_ce_n    (sram_ce_n),
    .sram_oe_n    (sram_oe_n),
    .sram_we_n    (sram_we_n),
    .sram_dq_out  (sram_dq_out),
    .sram_dq_oe   (sram_dq_oe),
    .sram_dq_in   (sram_dq_in),
    .snes_overrun (snes_overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Steps n cycles, clears SNES strobes after the first, drops mcu req on rdy, and profiles the pins.
  task automatic watch(input int n);
    n_ce = 0; n_oe = 0; n_we = 0; n_dqoe = 0; n_rdy = 0;
    f_ce = 0; l_ce = 0; f_we = 0; f_rdy = 0;
    f_addr = '0; l_addr = '0; f_dq = '0;
    for (int i = 1; i <= n; i++) begin
      tick();
      snes_rd_start = 0;
      snes_wr_start = 0;
      if (!sram_ce_n) begin
        n_ce++;
        if (f_ce == 0) begin
          f_ce = i;
          f_addr = sram_addr;
          f_dq = sram_dq_out;
        end
        l_ce = i;
        l_addr = sram_addr;
      end
      if (!sram_oe_n) n_oe++;
      if (!sram_we_n) begin
        n_we++;
        if (f_we == 0) f_we = i;
      end
      if (sram_dq_oe) n_dqoe++;
      if (mcu_bus.rdy) begin
        n_rdy++;
        if (f_rdy == 0) f_rdy = i;
        mcu_bus.req = 0;
      end
    end
  endtask
  initial begin
    mcu_bus.req = 0; mcu_bus.we = 0; mcu_bus.addr = '0; mcu_bus.wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_ce", sram_ce_n, 1);
    chk("rst_oe", sram_oe_n, 1);
    chk("rst_we", sram_we_n, 1);
    chk("rst_dqoe", sram_dq_oe, 0);
    chk("rst_rdy", mcu_bus.rdy, 0);
    chk("rst_ovr", snes_overrun, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_srd", snes_rd_data, 0);
    // SNES read
    rom_hit = 1; rom_addr = 24'h012345; sram_dq_in = 8'hA5; snes_rd_start = 1;
    watch(10);
    chk("srd_nce", n_ce, 6);
    chk("srd_noe", n_oe, 6);
    chk("srd_fce", f_ce, 1);
    chk("srd_nwe", n_we, 0);
    chk("srd_addr", l_addr, 24'h012345);
    chk("srd_data", snes_rd_data, 8'hA5);
    // MCU write on idle bus
    mcu_bus.req = 1; mcu_bus.we = 1; mcu_bus.addr = 24'hE00010; mcu_bus.wr_data = 8'h3C;
    watch(10);
    chk("mwr_nce", n_ce, 5);
    chk("mwr_nwe", n_we, 3);
    chk("mwr_fwe", f_we, 2);
    chk("mwr_ndqoe", n_dqoe, 5);
    chk("mwr_noe", n_oe, 0);
    chk("mwr_addr", f_addr, 24'hE00010);
    chk("mwr_dq", f_dq, 8'h3C);
    chk("mwr_nrdy", n_rdy, 1);
    chk("mwr_frdy", f_rdy, 6);
    // MCU read interrupted by SNES read request at cycle 2: no gap between them
    mcu_bus.req = 1; mcu_bus.we = 0; mcu_bus.addr = 24'h000100; sram_dq_in = 8'h5A;
    tick();
    tick();
    rom_addr = 24'h222222; snes_rd_start = 1;
    tick();
    snes_rd_start = 0;
    watch(12);
    chk("mix_nce", n_ce, 8);
    chk("mix_lce", l_ce, 8);
    chk("mix_noe", n_oe, 8);
    chk("mix_frdy", f_rdy, 3);
    chk("mix_addr", l_addr, 24'h222222);
    chk("mix_mrd", mcu_bus.rd_data, 8'h5A);
    chk("mix_srd", snes_rd_data, 8'h5A);
    chk("mix_ovr", snes_overrun, 0);
    // Non-writable SNES write is dropped, writable one runs
    rom_addr = 24'h300000; snes_wr_data = 8'h77; is_writable = 0; snes_wr_start = 1;
    watch(8);
    chk("nwr_nce", n_ce, 0);
    is_writable = 1; snes_wr_start = 1;
    watch(10);
    chk("swr_nce", n_ce, 6);
    chk("swr_nwe", n_we, 4);
    chk("swr_fwe", f_we, 2);
    chk("swr_ndqoe", n_dqoe, 6);
    chk("swr_noe", n_oe, 0);
    chk("swr_addr", f_addr, 24'h300000);
    chk("swr_dq", f_dq, 8'h77);
    // Simultaneous SNES start and MCU request: SNES first, MCU right after
    rom_addr = 24'h005000; snes_rd_start = 1;
    mcu_bus.req = 1; mcu_bus.we = 1; mcu_bus.addr = 24'h000100; mcu_bus.wr_data = 8'h11;
    watch(14);
    chk("sim_faddr", f_addr, 24'h005000);
    chk("sim_laddr", l_addr, 24'h000100);
    chk("sim_nce", n_ce, 11);
    chk("sim_noe", n_oe, 6);
    chk("sim_fwe", f_we, 8);
    chk("sim_frdy", f_rdy, 12);
    // Two SNES reads two cycles apart: overrun, second address serviced
    sram_dq_in = 8'hC3; rom_addr = 24'h000AAA; snes_rd_start = 1;
    tick();
    snes_rd_start = 0;
    tick();
    rom_addr = 24'h000BBB; snes_rd_start = 1;
    tick();
    snes_rd_start = 0;
    chk("ovr_flag", snes_overrun, 1);
    chk("ovr_addr1", sram_addr, 24'h000AAA);
    watch(12);
    chk("ovr_nce", n_ce, 9);
    chk("ovr_lce", l_ce, 9);
    chk("ovr_addr2", l_addr, 24'h000BBB);
    chk("ovr_srd", snes_rd_data, 8'hC3);
    // Reset in the middle of a SNES write with another write pending
    rom_addr = 24'h400000; snes_wr_start = 1;
    tick();
    snes_wr_start = 0;
    tick();
    snes_wr_start = 1;
    tick();
    snes_wr_start = 0;
    chk("mrst_we_pre", sram_we_n, 0);
    rst_n = 0;
    #1;
    chk("mrst_ce", sram_ce_n, 1);
    chk("mrst_we", sram_we_n, 1);
    chk("mrst_dqoe", sram_dq_oe, 0);
    chk("mrst_ovr", snes_overrun, 0);
    tick();
    tick();
    rst_n = 1;
    watch(8);
    chk("mrst_nce", n_ce, 0);
    chk("mrst_nrdy", n_rdy, 0);
    chk("mrst_ovr2", snes_overrun, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
